hilbert_iq_mac: RTL and testbench

- Sequential, parametrised Hilbert transformer that produces an analytic-signal pair (I, Q) plus squared envelope from one real sample stream.
- Supersedes the fully parallel combinational-MAC Hilbert filter. Adds reset, a valid/ready input handshake, decimation and saturating rounding.
- Uses one time-multiplexed multiplier with antisymmetric pre-subtraction.
- Sits between the ADC sample interface and the envelope/phase detector in the driver datapath.

---
 rtl/hilbert_iq_mac.sv | 215 +++++++++++++++++++++
 tb/tb_hilbert_iq_mac.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_iq_mac.sv
// Sequential Hilbert transformer: one shared multiplier walks the odd taps of an
// antisymmetric FIR and emits rounded/saturated I, Q and squared envelope.
module hilbert_iq_mac #(
    parameter int BITS_DATA     = 8,
    parameter int BITS_COEFF    = 8,
    parameter int TAPS          = 15,
    parameter int DECIMATION    = 1,
    parameter int OFFSET_BINARY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BITS_DATA-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [BITS_DATA-1:0] i_out,
    output logic signed [BITS_DATA-1:0] q_out,
    output logic [2*BITS_DATA:0]        mag2_out,
    output logic                        out_valid
);

    localparam int M      = (TAPS - 1) / 2;
    localparam int NZ     = (TAPS + 1) / 4;
    localparam int ACC_W  = BITS_DATA + BITS_COEFF + 1 + $clog2(NZ);
    localparam int DIFF_W = BITS_DATA + 1;
    localparam int PROD_W = DIFF_W + BITS_COEFF;
    localparam int SQ_W   = 2 * BITS_DATA;
    localparam int MAG_W  = 2 * BITS_DATA + 1;
    localparam int TAP_W  = (NZ > 1) ? $clog2(NZ) : 1;
    localparam int DEC_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;

    localparam logic [TAP_W-1:0]        TAP_LAST   = TAP_W'(NZ - 1);
    localparam logic [DEC_W-1:0]        DEC_LAST   = DEC_W'(DECIMATION - 1);
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (BITS_COEFF - 2));
    localparam logic signed [ACC_W-1:0] Q_MAX      = ACC_W'((2 ** (BITS_DATA - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Q_MIN      = ACC_W'(-(2 ** (BITS_DATA - 1)));

    if (TAPS % 4 != 3) begin : g_bad_taps
        $error("hilbert_iq_mac: TAPS must be odd with TAPS mod 4 == 3");
    end
    if (DECIMATION < 1) begin : g_bad_dec
        $error("hilbert_iq_mac: DECIMATION must be at least 1");
    end
    if (BITS_COEFF < 2 || BITS_DATA < 2) begin : g_bad_width
        $error("hilbert_iq_mac: BITS_DATA and BITS_COEFF must be at least 2");
    end

    // Ideal Hilbert tap 2/(pi*k) scaled to Q(BITS_COEFF-1), rounded half up.
    function automatic int calc_coeff(input int k);
        real v;
        v = (2.0 ** (BITS_COEFF - 1)) * 2.0 / (3.14159265358979 * k);
        return $rtoi(v + 0.5);
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_OUT} state_e;

    state_e                      state_q, state_d;
    logic signed [BITS_DATA-1:0] line_q [TAPS];
    logic signed [BITS_DATA-1:0] line_d [TAPS];
    logic [DEC_W-1:0]            dec_cnt_q, dec_cnt_d;
    logic [TAP_W-1:0]            tap_q, tap_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d;
    logic signed [BITS_DATA-1:0] i_rnd_q, i_rnd_d, q_rnd_q, q_rnd_d;
    logic signed [BITS_DATA-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
    logic [MAG_W-1:0]            mag2_q, mag2_d;
    logic                        out_valid_q, out_valid_d;
    logic                        in_ready_q, in_ready_d;

    logic signed [BITS_COEFF-1:0] coeff_s [NZ];
    logic signed [BITS_DATA-1:0]  late_s  [NZ];
    logic signed [BITS_DATA-1:0]  early_s [NZ];
    logic signed [BITS_DATA-1:0]  conv_s;
    logic signed [DIFF_W-1:0]     diff_s;
    logic signed [PROD_W-1:0]     prod_s;
    logic signed [ACC_W-1:0]      round_s;
    logic signed [BITS_DATA-1:0]  q_sat_s;
    logic signed [SQ_W-1:0]       i_sq_s, q_sq_s;
    logic [MAG_W-1:0]             mag2_s;
    logic                         hs_s;

    // Per-step operand pair d[M+k], d[M-k] and constant c_k for k = 2g+1.
    for (genvar g = 0; g < NZ; g++) begin : g_tap
        localparam logic signed [BITS_COEFF-1:0] C_K = BITS_COEFF'(calc_coeff(2 * g + 1));
        assign coeff_s[g] = C_K;
        assign late_s[g]  = line_q[M + 2 * g + 1];
        assign early_s[g] = line_q[M - 2 * g - 1];
    end

    assign hs_s = in_valid & in_ready_q;

    // Offset-binary samples become two's complement by flipping the sign bit.
    always_comb begin
        conv_s = in_data;
        if (OFFSET_BINARY != 0) begin
            conv_s[BITS_DATA-1] = ~in_data[BITS_DATA-1];
        end else begin
            conv_s = in_data;
        end
    end

    // Shared MAC term, rounding/saturation and envelope arithmetic.
    always_comb begin
        diff_s  = DIFF_W'(late_s[tap_q]) - DIFF_W'(early_s[tap_q]);
        prod_s  = PROD_W'(coeff_s[tap_q]) * PROD_W'(diff_s);
        round_s = (acc_q + ROUND_BIAS) >>> (BITS_COEFF - 1);
        if (round_s > Q_MAX) begin
            q_sat_s = BITS_DATA'(Q_MAX);
        end else if (round_s < Q_MIN) begin
            q_sat_s = BITS_DATA'(Q_MIN);
        end else begin
            q_sat_s = BITS_DATA'(round_s);
        end
        i_sq_s = SQ_W'(i_rnd_q) * SQ_W'(i_rnd_q);
        q_sq_s = SQ_W'(q_rnd_q) * SQ_W'(q_rnd_q);
        mag2_s = {1'b0, i_sq_s} + {1'b0, q_sq_s};
    end

    // Control FSM: sample capture in IDLE, then accumulate, round and publish.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        dec_cnt_d   = dec_cnt_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        i_rnd_d     = i_rnd_q;
        q_rnd_d     = q_rnd_q;
        i_out_d     = i_out_q;
        q_out_d     = q_out_q;
        mag2_d      = mag2_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hs_s) begin
                    for (int n = TAPS - 1; n > 0; n--) begin
                        line_d[n] = line_q[n-1];
                    end
                    line_d[0] = conv_s;
                    if (dec_cnt_q == DEC_LAST) begin
                        dec_cnt_d = '0;
                        acc_d     = '0;
                        tap_d     = '0;
                        state_d   = S_ACCUM;
                    end else begin
                        dec_cnt_d = dec_cnt_q + DEC_W'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + ACC_W'(prod_s);
                if (tap_q == TAP_LAST) begin
                    state_d = S_ROUND;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_ROUND: begin
                q_rnd_d = q_sat_s;
                i_rnd_d = line_q[M];
                state_d = S_OUT;
            end
            S_OUT: begin
                i_out_d     = i_rnd_q;
                q_out_d     = q_rnd_q;
                mag2_d      = mag2_s;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int n = 0; n < TAPS; n++) begin
                line_q[n] <= '0;
            end
            dec_cnt_q   <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            i_rnd_q     <= '0;
            q_rnd_q     <= '0;
            i_out_q     <= '0;
            q_out_q     <= '0;
            mag2_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            dec_cnt_q   <= dec_cnt_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            i_rnd_q     <= i_rnd_d;
            q_rnd_q     <= q_rnd_d;
            i_out_q     <= i_out_d;
            q_out_q     <= q_out_d;
            mag2_q      <= mag2_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign i_out     = i_out_q;
    assign q_out     = q_out_q;
    assign mag2_out  = mag2_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hilbert_iq_mac.sv
// Directed bench for hilbert_iq_mac: three instances cover offset-binary input,
// two's-complement input and decimation by 4.
module tb_hilbert_iq_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid_a, in_valid_b, in_valid_c;
    logic        in_ready_a, in_ready_b, in_ready_c;
    logic signed [7:0] i_out_a, q_out_a, i_out_b, q_out_b, i_out_c, q_out_c;
    logic [16:0] mag2_a, mag2_b, mag2_c;
    logic        out_valid_a, out_valid_b, out_valid_c;

    int checks   = 0;
    int failures = 0;

    hilbert_iq_mac #(.OFFSET_BINARY(1), .DECIMATION(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .i_out(i_out_a), .q_out(q_out_a),
        .mag2_out(mag2_a), .out_valid(out_valid_a));

    hilbert_iq_mac #(.OFFSET_BINARY(0), .DECIMATION(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .i_out(i_out_b), .q_out(q_out_b),
        .mag2_out(mag2_b), .out_valid(out_valid_b));

    hilbert_iq_mac #(.OFFSET_BINARY(0), .DECIMATION(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .i_out(i_out_c), .q_out(q_out_c),
        .mag2_out(mag2_c), .out_valid(out_valid_c));

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int w);
        case (w)
            0:       return in_ready_a;
            1:       return in_ready_b;
            default: return in_ready_c;
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            0:       return out_valid_a;
            1:       return out_valid_b;
            default: return out_valid_c;
        endcase
    endfunction

    task automatic set_valid(input int w, input logic v);
        case (w)
            0:       in_valid_a = v;
            1:       in_valid_b = v;
            default: in_valid_c = v;
        endcase
    endtask

    // Offer one sample at a negedge once ready; returns at the negedge after capture.
    task automatic push(input int w, input logic [7:0] d);
        int k;
        k = 0;
        while (!get_ready(w) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", get_ready(w), 1);
        in_data = d;
        set_valid(w, 1'b1);
        @(negedge clk);
        set_valid(w, 1'b0);
    endtask

    // Push a trigger sample, check 6-cycle latency, optionally check outputs.
    task automatic run(input int w, input logic [7:0] d, input bit do_chk,
                       input int exp_i, input int exp_q, input int exp_m, input string tag);
        int lat;
        push(w, d);
        lat = 0;
        while (!get_ov(w) && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 6);
        if (do_chk) begin
            if (w == 0) begin
                chk({tag, "_i"}, i_out_a, exp_i);
                chk({tag, "_q"}, q_out_a, exp_q);
                chk({tag, "_mag2"}, mag2_a, exp_m);
            end else begin
                chk({tag, "_i"}, i_out_b, exp_i);
                chk({tag, "_q"}, q_out_b, exp_q);
                chk({tag, "_mag2"}, mag2_b, exp_m);
            end
        end
    endtask

    int imp_q [16] = '{-9, 0, -12, 0, -21, 0, -63, 0, 63, 0, 21, 0, 13, 0, 9, 0};

    initial begin
        int ov_cnt;
        int pulses;
        int total;
        int p;
        logic [7:0] v;

        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_valid_c = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", in_ready_a, 1);
        chk("rst_ov", out_valid_a, 0);
        chk("rst_i", i_out_a, 0);
        chk("rst_q", q_out_a, 0);
        chk("rst_mag2", mag2_a, 0);
        chk("rst_ready_c", in_ready_c, 1);

        // Offset-binary zero, then DC at +64.
        for (int n = 0; n < 20; n++) begin
            run(0, 8'h80, 1'b1, 0, 0, 0, $sformatf("zero%0d", n));
        end
        for (int n = 0; n < 20; n++) begin
            run(0, 8'hC0, (n >= 14), 64, 0, 4096, $sformatf("dc%0d", n));
        end

        // Reset during the second ACCUM cycle of an asymmetric window.
        push(0, 8'hFF);
        @(negedge clk);
        rst_n  = 1'b0;
        ov_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid_a) ov_cnt++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid_a) ov_cnt++;
        end
        chk("abort_no_ov", ov_cnt, 0);
        chk("abort_ready", in_ready_a, 1);
        chk("abort_i", i_out_a, 0);
        chk("abort_q", q_out_a, 0);
        chk("abort_mag2", mag2_a, 0);
        run(0, 8'h80, 1'b1, 0, 0, 0, "abort_line_zero");

        // Impulse of 100 walking through the two's-complement line.
        for (int n = 0; n < 16; n++) begin
            v = (n == 0) ? 8'd100 : 8'd0;
            run(1, v, 1'b1, (n == 7) ? 100 : 0, imp_q[n],
                ((n == 7) ? 10000 : 0) + imp_q[n] * imp_q[n], $sformatf("imp%0d", n));
        end

        // Positive saturation: late taps 127, early taps -128, centre 5.
        for (int n = 0; n < 15; n++) begin
            p = 14 - n;
            if (p == 7)          v = 8'd5;
            else if (p % 2 == 1) v = 8'd0;
            else if (p >= 8)     v = 8'h7F;
            else                 v = 8'h80;
            run(1, v, (n == 14), 5, 127, 16154, "sat_pos");
        end
        // Mirror pattern saturates negative, centre -3.
        for (int n = 0; n < 15; n++) begin
            p = 14 - n;
            if (p == 7)          v = 8'hFD;
            else if (p % 2 == 1) v = 8'd0;
            else if (p >= 8)     v = 8'h80;
            else                 v = 8'h7F;
            run(1, v, (n == 14), -3, -128, 16393, "sat_neg");
        end

        // Continuous in_valid: ready once every 7 cycles, output 7 negedges later.
        @(negedge clk);
        in_data    = 8'h00;
        in_valid_b = 1'b1;
        for (int s = 0; s <= 21; s++) begin
            chk($sformatf("hs_ready%0d", s), in_ready_b, (s % 7 == 0) ? 1 : 0);
            chk($sformatf("hs_ov%0d", s), out_valid_b, (s % 7 == 0 && s > 0) ? 1 : 0);
            if (s < 21) @(negedge clk);
        end
        in_valid_b = 1'b0;

        // Decimation by 4 on samples 3, 6, ..., 48.
        total = 0;
        for (int n = 1; n <= 16; n++) begin
            push(2, 8'(n * 3));
            pulses = 0;
            repeat (8) begin
                if (out_valid_c) pulses++;
                @(negedge clk);
            end
            total += pulses;
            chk($sformatf("dec_pulse%0d", n), pulses, (n % 4 == 0) ? 1 : 0);
            if (n == 8) begin
                chk("dec8_i", i_out_c, 3);
                chk("dec8_q", q_out_c, -11);
                chk("dec8_mag2", mag2_c, 130);
            end
            if (n == 16) begin
                chk("dec16_i", i_out_c, 27);
                chk("dec16_q", q_out_c, -15);
                chk("dec16_mag2", mag2_c, 954);
            end
        end
        chk("dec_total", total, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
